// File: rtl/fir_pkg.sv
// Shared constants, FSM encodings and index types for the FIR channel scheduler.
package fir_pkg;

    localparam int unsigned FIR_WIDTH = 18;
    localparam int unsigned FIR_TAPS  = 128;
    localparam int unsigned FIR_N_CH  = 4;
    localparam int unsigned FIR_CH_W  = $clog2(FIR_N_CH);

    localparam int unsigned ST_W = 3;

    typedef logic [ST_W-1:0]     state_t;
    typedef logic [FIR_CH_W-1:0] ch_idx_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_MAC   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_OUT   = 3'd4;

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin request arbiter; pointer moves past the served channel on advance.
module fir_rr_arbiter #(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    input  logic [CH_W-1:0] served,
    output logic [N_CH-1:0] grant_c,
    output logic [CH_W-1:0] grant_idx_c,
    output logic            any_c
);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] ptr_d;

    // Next pointer: the channel after the one just served, wrapping at N_CH.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (served == CH_W'(N_CH - 1)) ? '0 : served + CH_W'(1);
        end
    end

    // First requester at or after the pointer wins.
    always_comb begin : pick
        logic [CH_W:0]   sum;
        logic [CH_W-1:0] idx;
        grant_c     = '0;
        grant_idx_c = '0;
        any_c       = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sum = {1'b0, ptr_q} + (CH_W+1)'(i);
            idx = (sum >= (CH_W+1)'(N_CH)) ? CH_W'(sum - (CH_W+1)'(N_CH)) : CH_W'(sum);
            if (!any_c && req[idx]) begin
                any_c        = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
        end
    end

    // Pointer register; reset gives channel 0 top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one serial FIR MAC engine between N_CH sample channels.
module fir_channel_scheduler
    import fir_pkg::*;
#(
    parameter  int unsigned WIDTH   = FIR_WIDTH,
    parameter  int unsigned N_CH    = FIR_N_CH,
    parameter  int unsigned TAPS    = FIR_TAPS,
    parameter  int unsigned ENG_LAT = 2,
    localparam int unsigned CH_W    = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic [CH_W-1:0]         eng_ch,
    output logic                    eng_load,
    output logic signed [WIDTH-1:0] eng_sample,
    output logic                    eng_clr,
    output logic                    eng_en,
    input  logic signed [WIDTH-1:0] eng_result,
    output logic                    out_valid,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned LAT_W = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [CH_W-1:0]          eng_ch_q, eng_ch_d;
    logic signed [WIDTH-1:0]  eng_sample_q, eng_sample_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic signed [WIDTH-1:0]  out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     eng_load_q, eng_load_d;
    logic                     eng_clr_q, eng_clr_d;
    logic                     eng_en_q, eng_en_d;
    logic                     busy_q, busy_d;

    logic [N_CH-1:0]          grant_c;
    logic [CH_W-1:0]          grant_idx_c;
    logic                     any_c;
    logic                     idle_c;
    logic                     accept_c;
    logic                     handshake_c;
    logic [WIDTH-1:0]         sel_sample_c;

    fir_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (in_valid),
        .advance     (handshake_c),
        .served      (out_ch_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .any_c       (any_c)
    );

    // Accept only in IDLE; reset forces the ready strobe low as well.
    assign idle_c      = rst_n && (state_q == ST_IDLE);
    assign accept_c    = idle_c && any_c;
    assign handshake_c = (state_q == ST_OUT) && out_ready;
    assign in_ready    = idle_c ? grant_c : '0;

    // Mux the granted channel's sample out of the flat input bus.
    always_comb begin
        sel_sample_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (grant_idx_c == CH_W'(k)) sel_sample_c = in_data[k*WIDTH +: WIDTH];
        end
    end

    // Next-state, counters and registered output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        eng_ch_d     = eng_ch_q;
        eng_sample_d = eng_sample_q;
        out_ch_d     = out_ch_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    eng_ch_d     = grant_idx_c;
                    out_ch_d     = grant_idx_c;
                    eng_sample_d = sel_sample_c;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                if (cnt_q == CNT_W'(TAPS - 1)) begin
                    cnt_d   = '0;
                    lat_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (lat_q == LAT_W'(ENG_LAT - 1)) begin
                    lat_d       = '0;
                    out_data_d  = eng_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        eng_load_d = (state_d == ST_LOAD);
        eng_clr_d  = (state_d == ST_LOAD);
        eng_en_d   = (state_d == ST_MAC);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset may land mid-burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            lat_q        <= '0;
            eng_ch_q     <= '0;
            eng_sample_q <= '0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            eng_load_q   <= 1'b0;
            eng_clr_q    <= 1'b0;
            eng_en_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            eng_ch_q     <= eng_ch_d;
            eng_sample_q <= eng_sample_d;
            out_ch_q     <= out_ch_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            eng_load_q   <= eng_load_d;
            eng_clr_q    <= eng_clr_d;
            eng_en_q     <= eng_en_d;
            busy_q       <= busy_d;
        end
    end

    assign eng_ch     = eng_ch_q;
    assign eng_sample = eng_sample_q;
    assign eng_load   = eng_load_q;
    assign eng_clr    = eng_clr_q;
    assign eng_en     = eng_en_q;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler with a behavioural MAC engine model.
module tb_fir_channel_scheduler;

    localparam int WIDTH = 18;
    localparam int N_CH  = 4;
    localparam int TAPS  = 128;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_ready;
    logic [1:0]              eng_ch;
    logic                    eng_load;
    logic signed [WIDTH-1:0] eng_sample;
    logic                    eng_clr;
    logic                    eng_en;
    logic signed [WIDTH-1:0] eng_result;
    logic                    out_valid;
    logic [1:0]              out_ch;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_ready;
    logic                    busy;

    fir_channel_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .eng_ch     (eng_ch),
        .eng_load   (eng_load),
        .eng_sample (eng_sample),
        .eng_clr    (eng_clr),
        .eng_en     (eng_en),
        .eng_result (eng_result),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Engine model: result = sample - 63 only after exactly TAPS steps since a clear.
    logic signed [WIDTH-1:0] m_smp = '0;
    int                      m_cnt = 0;
    logic [1:0]              m_hist = '0;
    always @(posedge clk) begin
        if (eng_load) m_smp <= eng_sample;
        if (eng_clr) m_cnt <= 0;
        else if (eng_en) m_cnt <= m_cnt + 1;
        m_hist <= {m_hist[0], eng_en};
    end
    assign eng_result = (m_hist == 2'b10) ? ((m_cnt == TAPS) ? m_smp - 18'sd63 : -18'sd999)
                                          : 18'sh2AAAA;

    // Cycle bookkeeping sampled just before each rising edge.
    int cyc = 0, en_cnt = 0, viol = 0, g2_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (eng_en) en_cnt <= en_cnt + 1;
        if (in_ready != '0 && (busy || $countones(in_ready) != 1)) viol <= viol + 1;
        if (in_ready[2]) g2_cnt <= g2_cnt + 1;
    end

    int checks = 0, errors = 0;
    int last_hs = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        int          stall;
        int          exp_ch;
        logic [17:0] exp_data;
        bit          keep;
        int          gap;
    } txn_t;

    txn_t tbl[12];

    // One full transaction: accept, MAC burst, result, optional stall, handshake.
    task automatic run_txn(input txn_t t);
        int n, t_acc, en0, bad;
        logic [N_CH-1:0] g;
        in_valid  = t.req;
        out_ready = (t.stall == 0);
        #1;
        n = 0;
        while (in_ready == '0 && n < 400) begin
            @(negedge clk); #1; n++;
        end
        check("accept_grant", 64'(in_ready), 64'(1 << t.exp_ch));
        t_acc = cyc;
        en0   = en_cnt;
        if (t.gap != 0) check("accept_gap", 64'(t_acc - last_hs), 64'(t.gap));
        g = in_ready;
        @(negedge clk);
        if (!t.keep) in_valid = in_valid & ~g;
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk); n++;
        end
        check("latency", 64'(cyc - t_acc), 64'(132));
        check("mac_steps", 64'(en_cnt - en0), 64'(TAPS));
        check("out_ch", 64'(out_ch), 64'(t.exp_ch));
        check("out_data", 64'(out_data), 64'(t.exp_data));
        bad = 0;
        for (int s = 0; s < t.stall; s++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_ch != 2'(t.exp_ch) || out_data != t.exp_data ||
                in_ready != '0 || eng_en || eng_load) bad++;
        end
        if (t.stall > 0) check("stall_stable", 64'(bad), 64'(0));
        out_ready = 1'b1;
        last_hs   = cyc;
        @(negedge clk);
        check("out_valid_drop", 64'(out_valid), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g2_0, en0;
        txn_t tr;

        tbl[0]  = '{4'b0001,  0, 0, 18'd37, 1'b0, 0};
        tbl[1]  = '{4'b1111,  0, 1, 18'd47, 1'b1, 1};
        tbl[2]  = '{4'b1111,  0, 2, 18'd57, 1'b1, 1};
        tbl[3]  = '{4'b1111,  0, 3, 18'd67, 1'b1, 1};
        tbl[4]  = '{4'b1111,  0, 0, 18'd37, 1'b1, 1};
        tbl[5]  = '{4'b1111,  0, 1, 18'd47, 1'b0, 1};
        tbl[6]  = '{4'b0100, 50, 2, 18'd57, 1'b0, 1};
        tbl[7]  = '{4'b0001,  0, 0, 18'd37, 1'b0, 1};
        tbl[8]  = '{4'b0010,  0, 1, 18'd47, 1'b0, 1};
        tbl[9]  = '{4'b1010,  0, 3, 18'd67, 1'b0, 1};
        tbl[10] = '{4'b1010,  0, 1, 18'd47, 1'b0, 1};
        tbl[11] = '{4'b0010,  0, 1, 18'd47, 1'b0, 1};

        in_data   = {18'sd130, 18'sd120, 18'sd110, 18'sd100};
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("reset_outputs",
              64'({in_ready, eng_ch, eng_load, eng_sample, eng_clr, eng_en,
                   out_valid, out_ch, out_data, busy}), 64'(0));
        repeat (3) @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_txn(tbl[i]);

        // Request from channel 2 appears and vanishes while the engine is busy.
        g2_0      = g2_cnt;
        in_valid  = 4'b0001;
        out_ready = 1'b1;
        #1;
        check("wd_grant", 64'(in_ready), 64'(4'b0001));
        @(negedge clk);
        in_valid = '0;
        repeat (20) @(negedge clk);
        in_valid = 4'b0100;
        repeat (60) @(negedge clk);
        in_valid = '0;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk); n++;
        end
        check("wd_out_ch", 64'(out_ch), 64'(0));
        check("wd_out_data", 64'(out_data), 64'(18'd37));
        repeat (5) @(negedge clk);
        check("wd_idle", 64'(busy), 64'(0));
        check("wd_no_grant_ch2", 64'(g2_cnt - g2_0), 64'(0));

        // Asynchronous reset in the middle of a MAC burst.
        in_valid = 4'b1000;
        #1;
        check("rst_grant", 64'(in_ready), 64'(4'b1000));
        en0 = en_cnt;
        n   = 0;
        while ((en_cnt - en0) < 60 && n < 200) begin
            @(negedge clk); n++;
        end
        check("rst_reached_step60", 64'(busy && eng_en), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({in_ready, eng_ch, eng_load, eng_sample, eng_clr, eng_en,
                   out_valid, out_ch, out_data, busy}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tr = '{4'b1000, 0, 3, 18'd67, 1'b0, 0};
        run_txn(tr);

        check("in_ready_rules", 64'(viol), 64'(0));
        in_valid = '0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
